// File: rtl/lc3_int_arbiter.sv
// lc3_int_arbiter: multi-source interrupt arbiter with request/acknowledge handshake to the LC3 control FSM.
// Optional macro LC3_INT_EDGE_EN selects edge-triggered pending bits; level mode otherwise.
`default_nettype none

module lc3_int_arbiter #(
    parameter int                     NUM_SRC  = 4,
    parameter logic [3*NUM_SRC-1:0]   PRIO     = {3'd4, 3'd4, 3'd1, 3'd4},
    parameter logic [7:0]             VEC_BASE = 8'h80
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] IRQ,
    input  logic [NUM_SRC-1:0] IE,
    input  logic [2:0]         CPU_PL,
    input  logic               INT_ACK,
    output logic               INT_REQ,
    output logic [2:0]         INT_Priority,
    output logic [7:0]         INTV,
    output logic [NUM_SRC-1:0] PENDING
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t             r_state;
    logic [2:0]         r_win;
    logic [NUM_SRC-1:0] r_pending;

    logic [NUM_SRC-1:0] w_elig;
    logic [NUM_SRC-1:0] w_win_mask;
    logic               w_any;
    logic [2:0]         w_best_idx;
    logic [2:0]         w_best_prio;
    logic               w_win_still;

    // Strict '>' on priority keeps the lowest index on ties.
    always_comb begin
        w_elig      = '0;
        w_win_mask  = '0;
        w_any       = 1'b0;
        w_best_idx  = 3'd0;
        w_best_prio = 3'd0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_elig[i] = r_pending[i] & IE[i] & (PRIO[3*i +: 3] > CPU_PL);
            if (r_win == 3'(i)) begin
                w_win_mask[i] = 1'b1;
            end
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_elig[i] && (!w_any || (PRIO[3*i +: 3] > w_best_prio))) begin
                w_any       = 1'b1;
                w_best_idx  = 3'(i);
                w_best_prio = PRIO[3*i +: 3];
            end
        end
        w_win_still = |(w_win_mask & w_elig);
    end

`ifdef LC3_INT_EDGE_EN
    logic [NUM_SRC-1:0] r_irq_q;
    logic [NUM_SRC-1:0] w_ack_clr;

    assign w_ack_clr = ((r_state == REQ) && INT_ACK) ? w_win_mask : '0;

    // A new rising edge overrides a same-cycle acknowledge clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq_q   <= '0;
            r_pending <= '0;
        end else begin
            r_irq_q   <= IRQ;
            r_pending <= (r_pending & ~w_ack_clr) | (IRQ & ~r_irq_q);
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= IRQ;
        end
    end
`endif

    assign PENDING = r_pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_win        <= 3'd0;
            INT_REQ      <= 1'b0;
            INT_Priority <= 3'd0;
            INTV         <= VEC_BASE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_win        <= w_best_idx;
                        INT_Priority <= w_best_prio;
                        INTV         <= VEC_BASE + {5'd0, w_best_idx};
                        INT_REQ      <= 1'b1;
                        r_state      <= REQ;
                    end
                end
                REQ: begin
                    // Acknowledge takes precedence over withdrawal.
                    if (INT_ACK || !w_win_still) begin
                        INT_REQ <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    INT_REQ <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lc3_int_arbiter.sv
// Directed self-checking bench for lc3_int_arbiter (level mode by default, edge mode under LC3_INT_EDGE_EN).
`default_nettype none

module tb_lc3_int_arbiter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] IRQ;
    logic [N-1:0] IE;
    logic [2:0]   CPU_PL;
    logic         INT_ACK;
    logic         INT_REQ;
    logic [2:0]   INT_Priority;
    logic [7:0]   INTV;
    logic [N-1:0] PENDING;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Source 0 priority 1, sources 1..3 priority 4.
    lc3_int_arbiter #(
        .NUM_SRC  (N),
        .PRIO     ({3'd4, 3'd4, 3'd4, 3'd1}),
        .VEC_BASE (8'h80)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .IRQ          (IRQ),
        .IE           (IE),
        .CPU_PL       (CPU_PL),
        .INT_ACK      (INT_ACK),
        .INT_REQ      (INT_REQ),
        .INT_Priority (INT_Priority),
        .INTV         (INTV),
        .PENDING      (PENDING)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; IRQ = '0; IE = '0; CPU_PL = 3'd0; INT_ACK = 1'b0;
        tick; tick;
        chk("rst_req",  32'(INT_REQ), 32'd0);
        chk("rst_pend", 32'(PENDING), 32'd0);
        chk("rst_intv", 32'(INTV), 32'h80);
        chk("rst_prio", 32'(INT_Priority), 32'd0);
        rst_n = 1'b1;
        tick;

        // Single source 0
        IE = 4'b0001; IRQ = 4'b0001;
        tick;
        chk("s0_pend", 32'(PENDING), 32'h1);
        chk("s0_noreq_yet", 32'(INT_REQ), 32'd0);
        tick;
        chk("s0_req", 32'(INT_REQ), 32'd1);
        chk("s0_prio", 32'(INT_Priority), 32'd1);
        chk("s0_intv", 32'(INTV), 32'h80);
        INT_ACK = 1'b1; IRQ = 4'b0000;
        tick;
        INT_ACK = 1'b0;
        chk("s0_ack_req", 32'(INT_REQ), 32'd0);
        chk("s0_ack_pend", 32'(PENDING), 32'd0);
        tick;
        chk("s0_idle_req", 32'(INT_REQ), 32'd0);
        chk("s0_hold_intv", 32'(INTV), 32'h80);

        // Priority and tie-break
        IE = 4'b1111; IRQ = 4'b1110;
        tick;
        chk("tie_pend", 32'(PENDING), 32'hE);
        tick;
        chk("tie_req1", 32'(INT_REQ), 32'd1);
        chk("tie_intv1", 32'(INTV), 32'h81);
        chk("tie_prio1", 32'(INT_Priority), 32'd4);
        INT_ACK = 1'b1; IRQ = 4'b1100;
        tick;
        INT_ACK = 1'b0;
        chk("tie_ack1", 32'(INT_REQ), 32'd0);
        chk("tie_pend1", 32'(PENDING), 32'hC);
        tick;
        chk("tie_req2", 32'(INT_REQ), 32'd1);
        chk("tie_intv2", 32'(INTV), 32'h82);
        INT_ACK = 1'b1; IRQ = 4'b1000;
        tick;
        INT_ACK = 1'b0;
        chk("tie_ack2", 32'(INT_REQ), 32'd0);
        tick;
        chk("tie_req3", 32'(INT_REQ), 32'd1);
        chk("tie_intv3", 32'(INTV), 32'h83);
        INT_ACK = 1'b1; IRQ = 4'b0000;
        tick;
        INT_ACK = 1'b0;
        chk("tie_ack3", 32'(INT_REQ), 32'd0);
        chk("tie_pend3", 32'(PENDING), 32'd0);
        tick;

        // Priority-level gating and withdrawal
        IRQ = 4'b0010;
        tick; tick;
        chk("pl_req", 32'(INT_REQ), 32'd1);
        CPU_PL = 3'd4;
        tick;
        chk("pl_withdraw", 32'(INT_REQ), 32'd0);
        chk("pl_pend_kept", 32'(PENDING), 32'h2);
        tick;
        chk("pl_blocked", 32'(INT_REQ), 32'd0);
        CPU_PL = 3'd3;
        tick;
        chk("pl_rereq", 32'(INT_REQ), 32'd1);
        chk("pl_rereq_intv", 32'(INTV), 32'h81);
        IE = 4'b1101;
        tick;
        chk("ie_withdraw", 32'(INT_REQ), 32'd0);
        IE = 4'b1111;
        tick;
        chk("ie_rereq", 32'(INT_REQ), 32'd1);
        INT_ACK = 1'b1; IRQ = 4'b0000;
        tick;
        INT_ACK = 1'b0; CPU_PL = 3'd0;
        chk("pl_ack", 32'(INT_REQ), 32'd0);
        tick;

        // No preemption while REQ; ACK in IDLE ignored
        IRQ = 4'b0001; INT_ACK = 1'b1;
        tick;
        INT_ACK = 1'b0;
        chk("idle_ack_pend", 32'(PENDING), 32'h1);
        tick;
        chk("np_req", 32'(INT_REQ), 32'd1);
        chk("np_intv0", 32'(INTV), 32'h80);
        IRQ = 4'b0011;
        tick;
        chk("np_frozen_req", 32'(INT_REQ), 32'd1);
        chk("np_frozen_intv", 32'(INTV), 32'h80);
        chk("np_frozen_prio", 32'(INT_Priority), 32'd1);
        INT_ACK = 1'b1; IRQ = 4'b0010;
        tick;
        INT_ACK = 1'b0;
        chk("np_ack", 32'(INT_REQ), 32'd0);
        tick;
        chk("np_next_req", 32'(INT_REQ), 32'd1);
        chk("np_next_intv", 32'(INTV), 32'h81);
        INT_ACK = 1'b1; IRQ = 4'b0000;
        tick;
        INT_ACK = 1'b0;
        tick;

`ifdef LC3_INT_EDGE_EN
        // One-cycle pulse is latched, then ACK clear races a new rising edge
        IRQ = 4'b0001;
        tick;
        IRQ = 4'b0000;
        tick;
        chk("e_pulse_req", 32'(INT_REQ), 32'd1);
        chk("e_pulse_pend", 32'(PENDING), 32'h1);
        INT_ACK = 1'b1; IRQ = 4'b0001;
        tick;
        INT_ACK = 1'b0;
        chk("e_sim_pend", 32'(PENDING), 32'h1);
        chk("e_sim_req0", 32'(INT_REQ), 32'd0);
        tick;
        chk("e_sim_rereq", 32'(INT_REQ), 32'd1);
        chk("e_sim_intv", 32'(INTV), 32'h80);
        INT_ACK = 1'b1;
        tick;
        INT_ACK = 1'b0;
        chk("e_held_pend", 32'(PENDING), 32'd0);
        tick;
        chk("e_held_noreq", 32'(INT_REQ), 32'd0);
        IRQ = 4'b0000;
        tick;
`else
        // Held level re-requests every two cycles until the device drops it
        IRQ = 4'b0001;
        tick; tick;
        chk("l_req_a", 32'(INT_REQ), 32'd1);
        INT_ACK = 1'b1;
        tick;
        INT_ACK = 1'b0;
        chk("l_ack_a", 32'(INT_REQ), 32'd0);
        chk("l_pend_held", 32'(PENDING), 32'h1);
        tick;
        chk("l_req_b", 32'(INT_REQ), 32'd1);
        INT_ACK = 1'b1; IRQ = 4'b0000;
        tick;
        INT_ACK = 1'b0;
        chk("l_ack_b", 32'(INT_REQ), 32'd0);
        chk("l_pend_drop", 32'(PENDING), 32'd0);
        tick;
        chk("l_no_req", 32'(INT_REQ), 32'd0);
`endif

        // Asynchronous reset in the middle of a request
        IRQ = 4'b0101; IE = 4'b1111; CPU_PL = 3'd0;
        tick;
        chk("r_pend", 32'(PENDING), 32'h5);
        tick;
        chk("r_req", 32'(INT_REQ), 32'd1);
        chk("r_intv", 32'(INTV), 32'h82);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_req", 32'(INT_REQ), 32'd0);
        chk("ar_pend", 32'(PENDING), 32'd0);
        chk("ar_intv", 32'(INTV), 32'h80);
        chk("ar_prio", 32'(INT_Priority), 32'd0);
        IRQ = 4'b0000;
        tick;
        rst_n = 1'b1;
        tick;
        chk("post_rst_req", 32'(INT_REQ), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lc3_int_arbiter.md
# lc3_int_arbiter

Multi-source interrupt arbiter for the LC3 core, generalising the single-keyboard interrupt path to up to eight devices (keyboard, display, timer, …). Latches device requests, applies per-source enables, selects the highest-priority eligible source, and runs a request/acknowledge handshake with the LC3 control FSM. Supplies the frozen winner's priority and 8-bit vector for the interrupt-entry microsequence.

## Interface
- NUM_SRC, 4, number of interrupt sources (1..8)
- PRIO, {3'd4,3'd4,3'd1,3'd4}, packed 3-bit priority per source; source i at bits [3i+2:3i]
- VEC_BASE, 8'h80, vector of source 0; source i vector = VEC_BASE + i

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- IRQ  in  NUM_SRC  device request lines (KB_INT is bit 0)
- IE  in  NUM_SRC  per-source enable (device status-register IE bits)
- CPU_PL  in  3  current PSR priority level
- INT_ACK  in  1  one-cycle acknowledge from control FSM
- INT_REQ  out  1  interrupt request to control FSM
- INT_Priority  out  3  priority of frozen winner
- INTV  out  8  vector of frozen winner
- PENDING  out  NUM_SRC  pending-register status

## Operation
- Pending register, one bit per source; PENDING mirrors it.
- Eligible(i) = PENDING[i] & IE[i] & (PRIO_i > CPU_PL). Priority 0 never eligible.
- Winner = eligible source with highest PRIO; ties -> lowest index.
- FSM states: IDLE, REQ.
  - IDLE: INT_REQ=0. If any eligible source, next edge: capture winner index, INT_Priority, INTV; INT_REQ=1; go REQ.
  - REQ: outputs frozen (no preemption by newer/higher sources). INT_ACK=1 -> next edge INT_REQ=0, go IDLE, winner's pending handled per Configuration. Winner no longer eligible (IE[w] cleared or CPU_PL >= frozen priority) with INT_ACK=0 -> withdraw: INT_REQ=0, go IDLE, pending retained.
  - INT_ACK and withdrawal in same cycle: ACK wins.
  - INT_ACK while IDLE: ignored.
- INTV = VEC_BASE + index, 8-bit modulo (wraps past 8'hFF).
- INT_Priority/INTV hold their last captured values in IDLE.

## Timing
- Reset (async): state IDLE, INT_REQ=0, INT_Priority=3'b000, INTV=VEC_BASE, PENDING=0.
- IRQ event sampled at edge t -> PENDING bit set at t; INT_REQ high at edge t+1 (one-cycle latency from pending to request).
- ACK sampled at edge t -> INT_REQ low and pending update at t; FSM spends at least one cycle in IDLE; earliest re-request at edge t+1.
- Pending clear (ACK) and new set on same source in same cycle: set wins.
- Reset mid-REQ: request dropped immediately, all pending lost.
- All outputs are registered; no combinational input-to-output paths.

## Configuration
- LC3_INT_EDGE_EN defined: pending bit set on IRQ rising edge (previous IRQ registered internally, reset 0), cleared only by ACK of that source; IRQ may pulse for one cycle.
- LC3_INT_EDGE_EN undefined: level mode; PENDING[i] <= IRQ[i] every cycle, ACK does not clear it; device must drop IRQ itself (LC3 KBSR-ready semantics).

## Test plan
- Reset: assert rst_n=0 mid-REQ with PENDING=4'b0101 -> INT_REQ=0, PENDING=0, INTV=8'h80, INT_Priority=0 asynchronously.
- Single source: CPU_PL=0, IE=4'b0001, pulse IRQ[0] (edge mode) -> INT_REQ at second edge after sample, INT_Priority=3'd1, INTV=8'h80; ACK -> INT_REQ=0, PENDING[0]=0.
- Priority/tie: IRQ[3:0]=4'b1110 together, all IE set, CPU_PL=0 -> winner source 1 (prio 4, lowest index), INTV=8'h81; after ACK next winner source 2 (8'h82), then source 3 (8'h83).
- PL gating/withdraw: source 1 in REQ, raise CPU_PL to 4 before ACK -> INT_REQ drops next edge, PENDING[1] stays 1; lower CPU_PL to 3 -> re-request INTV=8'h81.
- Simultaneous: ACK of source 0 in the same cycle as new IRQ[0] rising edge -> PENDING[0]=1 after edge, INT_REQ reasserts with INTV=8'h80 at ACK edge+1.
- Level mode (macro undefined): IRQ[0] held high through ACK -> re-request every 2 cycles; drop IRQ[0] -> PENDING[0]=0 next edge, no further request.
